// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - rounding mode encodings shared by the round/saturate stream
package round_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ROUND_FLOOR     = 2'b00,
        ROUND_HALF_DN   = 2'b01,
        ROUND_HALF_UP   = 2'b10,
        ROUND_HALF_EVEN = 2'b11
    } mode_t;

endpackage

// File: rtl/round_sat_stream_if.sv
// rtl/round_sat_stream_if.sv - sample-in / result-out handshake bundle
interface round_sat_stream_if
    import round_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/round_sat_core.sv
// rtl/round_sat_core.sv - bias add (front half) and shift/tie/clip (back half), purely combinational
module round_sat_core
    import round_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 8
) (
    input  logic [IN_W-1:0]  in_data,
    input  mode_t            in_mode,
    output logic [IN_W:0]    sum,
    output logic             tie,
    input  logic [IN_W:0]    sum_q,
    input  mode_t            mode_q,
    input  logic             tie_q,
    output logic [OUT_W-1:0] res,
    output logic             sat
);

    localparam int            QW   = IN_W + 1 - FRAC_W;
    localparam logic [IN_W:0] ONE  = {{IN_W{1'b0}}, 1'b1};
    localparam logic [IN_W:0] HALF = ONE << (FRAC_W - 1);

    logic [IN_W:0]     bias;
    logic [QW-1:0]     q;
    logic [QW-OUT_W:0] hi;
    logic              unused_frac;

    always_comb begin
        bias = '0;
        case (in_mode)
            ROUND_FLOOR:   bias = '0;
            ROUND_HALF_DN: bias = HALF - ONE;
            default:       bias = HALF;
        endcase
    end

    // One guard bit above the sign keeps the biased sum from wrapping.
    assign sum = {in_data[IN_W-1], in_data} + bias;
    assign tie = (in_data[FRAC_W-1:0] == HALF[FRAC_W-1:0]);

    always_comb begin
        q = sum_q[IN_W:FRAC_W];
        if (mode_q == ROUND_HALF_EVEN && tie_q) begin
            q[0] = 1'b0;
        end
    end

    // Fits in OUT_W signed bits exactly when all bits from OUT_W-1 upward agree.
    assign hi  = q[QW-1:OUT_W-1];
    assign sat = ~((&hi) | ~(|hi));
    assign res = sat ? {q[QW-1], {(OUT_W-1){~q[QW-1]}}} : q[OUT_W-1:0];

    assign unused_frac = ^sum_q[FRAC_W-1:0];

endmodule

// File: rtl/round_sat_stream.sv
// rtl/round_sat_stream.sv - two-stage round/saturate pipeline with handshake and saturation counter
module round_sat_stream
    import round_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    round_sat_stream_if.slave bus,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sat_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [IN_W:0]    s1_sum;
    mode_t            s1_mode;
    logic             s1_tie;
    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;
    logic             s2_sat;

    logic [IN_W:0]    sum_d;
    logic             tie_d;
    logic [OUT_W-1:0] res_d;
    logic             sat_d;
    logic             s1_adv;
    logic             s2_adv;

    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_sat   = s2_sat;

    round_sat_core #(
        .IN_W   (IN_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_core (
        .in_data (bus.in_data),
        .in_mode (mode_t'(bus.in_mode)),
        .sum     (sum_d),
        .tie     (tie_d),
        .sum_q   (s1_sum),
        .mode_q  (s1_mode),
        .tie_q   (s1_tie),
        .res     (res_d),
        .sat     (sat_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= bus.in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // Stage-1 payload needs no reset: it is only consumed behind s1_valid.
    always_ff @(posedge clk) begin
        if (s1_adv && bus.in_valid) begin
            s1_sum  <= sum_d;
            s1_mode <= mode_t'(bus.in_mode);
            s1_tie  <= tie_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data <= '0;
            s2_sat  <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            s2_data <= res_d;
            s2_sat  <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sat_count <= '0;
        end else if (s2_valid && bus.out_ready && s2_sat && sat_count != CNT_MAX) begin
            sat_count <= sat_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_round_sat_stream.sv
// tb/tb_round_sat_stream.sv - scoreboard bench for the round/saturate stream
module tb_round_sat_stream;
    import round_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         acc;
        bit         lat;
        bit         gap;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [7:0]  e;
        logic        s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr0, clr1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_acc = 0;
    int   last0 = 0, last1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    round_sat_stream_if #(.IN_W(16), .OUT_W(8)) if0 ();
    round_sat_stream_if #(.IN_W(16), .OUT_W(6)) if1 ();

    round_sat_stream #(.IN_W(16), .FRAC_W(8), .OUT_W(8), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .cnt_clr(clr0), .sat_count(cnt0)
    );

    round_sat_stream #(.IN_W(16), .FRAC_W(8), .OUT_W(6), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .cnt_clr(clr1), .sat_count(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int sel, input logic [15:0] d, input logic [1:0] m,
                        input logic [7:0] ed, input logic es, input bit lat, input bit gap);
        bit   rdy;
        bit   done;
        int   acc;
        exp_t e;
        done = 0;
        if (sel == 0) begin
            if0.in_valid = 1'b1; if0.in_data = d; if0.in_mode = m;
        end else begin
            if1.in_valid = 1'b1; if1.in_data = d; if1.in_mode = m;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? if0.in_ready : if1.in_ready;
            acc = cyc;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                e.d = ed; e.s = es; e.acc = acc; e.lat = lat; e.gap = gap;
                if (sel == 0) q0.push_back(e); else q1.push_back(e);
                n_acc++;
            end
        end
        if (!done) chk($sformatf("accept_timeout dut%0d", sel), 32'd0, 32'd1);
        if (sel == 0) if0.in_valid = 1'b0; else if1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain pending", q0.size() + q1.size(), 0);
    endtask

    task automatic score(input int sel, input logic [7:0] d, input logic s);
        exp_t e;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_out dut%0d", sel), {24'd0, d}, 32'hFFFF_FFFF);
            return;
        end
        if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("dut%0d out_data", sel), {24'd0, d}, {24'd0, e.d});
        chk($sformatf("dut%0d out_sat", sel), {31'd0, s}, {31'd0, e.s});
        if (e.lat) chk($sformatf("dut%0d latency", sel), cyc - e.acc, 2);
        if (e.gap) chk($sformatf("dut%0d gap", sel), cyc, ((sel == 0) ? last0 : last1) + 1);
        if (sel == 0) last0 = cyc; else last1 = cyc;
    endtask

    // Monitor: pops on every transfer and checks that stalled outputs hold.
    initial begin
        bit         hv0, hv1;
        logic [7:0] hd0, hd1;
        logic       hs0, hs1;
        hv0 = 0; hv1 = 0; hd0 = '0; hd1 = '0; hs0 = 0; hs1 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hv0 = 0; hv1 = 0;
            end else begin
                if (if0.out_valid) begin
                    if (hv0) chk("dut0 stall hold", {23'd0, if0.out_sat, if0.out_data}, {23'd0, hs0, hd0});
                    if (if0.out_ready) begin
                        hv0 = 0;
                        score(0, if0.out_data, if0.out_sat);
                    end else begin
                        hv0 = 1; hd0 = if0.out_data; hs0 = if0.out_sat;
                    end
                end
                if (if1.out_valid) begin
                    if (hv1) chk("dut1 stall hold", {23'd0, if1.out_sat, 2'b00, if1.out_data}, {23'd0, hs1, hd1});
                    if (if1.out_ready) begin
                        hv1 = 0;
                        score(1, {2'b00, if1.out_data}, if1.out_sat);
                    end else begin
                        hv1 = 1; hd1 = {2'b00, if1.out_data}; hs1 = if1.out_sat;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v0[11];
        vec_t v1[3];
        v0 = '{
            '{16'h0180, 2'd0, 8'h01, 1'b0},
            '{16'h0180, 2'd1, 8'h01, 1'b0},
            '{16'h0180, 2'd2, 8'h02, 1'b0},
            '{16'h0180, 2'd3, 8'h02, 1'b0},
            '{16'h0280, 2'd3, 8'h02, 1'b0},
            '{16'hFF80, 2'd0, 8'hFF, 1'b0},
            '{16'h7F80, 2'd2, 8'h7F, 1'b1},
            '{16'h8000, 2'd2, 8'h80, 1'b0},
            '{16'hFE80, 2'd1, 8'hFE, 1'b0},
            '{16'hFE80, 2'd3, 8'hFE, 1'b0},
            '{16'h7F80, 2'd1, 8'h7F, 1'b0}
        };
        v1 = '{
            '{16'hE000, 2'd0, 8'h20, 1'b0},
            '{16'hDF00, 2'd0, 8'h20, 1'b1},
            '{16'h2000, 2'd0, 8'h1F, 1'b1}
        };

        clr0 = 1'b0; clr1 = 1'b0;
        if0.in_valid = 1'b1; if0.in_data = 16'h0100; if0.in_mode = 2'd0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_data = '0;       if1.in_mode = 2'd0; if1.out_ready = 1'b1;

        // Reset with a sample offered on dut0: it must not be taken.
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid0", {31'd0, if0.out_valid}, 0);
        chk("rst out_data0", {24'd0, if0.out_data}, 0);
        chk("rst out_sat0", {31'd0, if0.out_sat}, 0);
        chk("rst sat_count0", {16'd0, cnt0}, 0);
        chk("rst out_valid1", {31'd0, if1.out_valid}, 0);
        chk("rst sat_count1", {28'd0, cnt1}, 0);
        rst = 1'b0;
        if0.in_valid = 1'b0;
        chk("in_ready after rst", {31'd0, if0.in_ready}, 1);

        // Rounding modes, ties and full-scale boundaries.
        foreach (v0[i]) send(0, v0[i].d, v0[i].m, v0[i].e, v0[i].s, 1, 0);
        drain();
        chk("sat_count0 after modes", {16'd0, cnt0}, 1);

        // Backpressure: two accepts fill the pipe, then in-order, gapless release.
        if0.out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int k = 1; k <= 4; k++)
                    send(0, 16'(k) << 8, 2'd0, 8'(k), 1'b0, 0, k != 1);
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("accepts while stalled", n_acc, 2);
                chk("in_ready while stalled", {31'd0, if0.in_ready}, 0);
                chk("out_data while stalled", {24'd0, if0.out_data}, 1);
                if0.out_ready = 1'b1;
            end
        join
        drain();

        // Narrow output: clip boundaries.
        foreach (v1[i]) send(1, v1[i].d, v1[i].m, v1[i].e, v1[i].s, 1, 0);
        drain();
        chk("sat_count1 after clip", {28'd0, cnt1}, 2);

        // Counter saturates at all-ones after 20 saturated transfers.
        for (int k = 0; k < 18; k++) send(1, 16'h2000, 2'd0, 8'h1F, 1'b1, 1, 0);
        drain();
        chk("sat_count1 held at max", {28'd0, cnt1}, 15);

        // Clear coinciding with a counted transfer.
        if1.out_ready = 1'b0;
        send(1, 16'h2000, 2'd0, 8'h1F, 1'b1, 0, 0);
        for (int n = 0; n < 10 && !if1.out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        chk("dut1 out_valid before clr", {31'd0, if1.out_valid}, 1);
        clr1 = 1'b1;
        if1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr1 = 1'b0;
        chk("sat_count1 clr wins", {28'd0, cnt1}, 0);
        send(1, 16'h2000, 2'd0, 8'h1F, 1'b1, 1, 0);
        drain();
        chk("sat_count1 after clr", {28'd0, cnt1}, 1);

        // Mid-stream reset with both stages full.
        if0.out_ready = 1'b0;
        send(0, 16'h0100, 2'd0, 8'h01, 1'b0, 0, 0);
        send(0, 16'h0200, 2'd0, 8'h02, 1'b0, 0, 0);
        chk("pipe full out_valid0", {31'd0, if0.out_valid}, 1);
        chk("pipe full in_ready0", {31'd0, if0.in_ready}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        chk("mid rst out_valid0", {31'd0, if0.out_valid}, 0);
        chk("mid rst sat_count0", {16'd0, cnt0}, 0);
        chk("mid rst in_ready0", {31'd0, if0.in_ready}, 1);
        if0.out_ready = 1'b1;
        send(0, 16'h0300, 2'd2, 8'h03, 1'b0, 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_sat_stream.md
ROUND_SAT_STREAM -- requirements
Module: round_sat_stream

Interface
REQ-001 Parameter IN_W, default 16, signed fixed-point input width.
REQ-002 Parameter FRAC_W, default 8, fractional bits of input; legal range 1..IN_W-2.
REQ-003 Parameter OUT_W, default 8, signed integer output width; legal range 2..IN_W-FRAC_W+1.
REQ-004 Parameter CNT_W, default 16, saturation-event counter width.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 in_valid  input  1  input sample valid.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 in_data  input  IN_W  signed fixed-point sample, FRAC_W fractional bits.
REQ-010 in_mode  input  2  rounding mode, captured with the sample.
REQ-011 out_valid  output  1  output sample valid.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 out_data  output  OUT_W  signed rounded, saturated integer.
REQ-014 out_sat  output  1  out_data was clipped; aligned with out_data.
REQ-015 cnt_clr  input  1  clears sat_count.
REQ-016 sat_count  output  CNT_W  number of saturated samples transferred on output.

Function
REQ-017 Modes: 00 floor; 01 nearest, ties toward -inf (bias 0.5-1 LSB); 10 nearest, ties toward +inf (bias 0.5); 11 nearest, ties to even.
REQ-018 Rounded value = floor((in_data + bias) / 2^FRAC_W), with the addition evaluated at IN_W+1 bits so it never wraps; mode 11 adds bias 0.5 and then clears bit 0 of the result when the fraction is exactly 0.5.
REQ-019 The result clips to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 only when the clip changes the value.
REQ-020 Two-stage pipeline: stage 1 registers the biased sum, mode and tie flag; stage 2 registers the saturated out_data and out_sat.
REQ-021 Latency is 2 cycles from accept (in_valid&&in_ready) to out_valid when out_ready is held high; throughput is 1 sample/cycle.
REQ-022 Stage 2 advances when !s2_valid||out_ready; stage 1 advances when !s1_valid||stage-2 advance; in_ready = stage-1 advance.
REQ-023 While out_valid&&!out_ready, out_data and out_sat stay stable; samples are never dropped, duplicated or reordered.
REQ-024 A change of in_mode between samples affects only samples accepted after the change.
REQ-025 sat_count increments by 1 on each output transfer (out_valid&&out_ready) with out_sat=1, and holds at all-ones.
REQ-026 When cnt_clr and a counted transfer occur in the same cycle, cnt_clr wins and sat_count becomes 0.
REQ-027 in_ready does not depend combinationally on in_valid.

Reset
REQ-028 On rst: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0, sat_count=0.
REQ-029 in_ready=1 in the cycle after reset deasserts.
REQ-030 rst asserted mid-stream discards all in-flight samples at the next edge.
REQ-031 During rst, in_valid is ignored.

Structure
REQ-032 Mode encodings (ROUND_FLOOR, ROUND_HALF_DN, ROUND_HALF_UP, ROUND_HALF_EVEN) live in shared package round_pkg.
REQ-033 The bias, shift and clip arithmetic lives in one combinational sub-module, round_sat_core, parametrised by IN_W, FRAC_W and OUT_W; round_sat_stream holds the pipeline, handshake and counter.

Verification
REQ-034 Defaults, out_ready=1, 1.5 (0x0180) sent in modes 00/01/10/11 -> 1, 1, 2, 2; 2.5 (0x0280) in mode 11 -> 2; -0.5 (0xFF80) in mode 00 -> 0xFF. Each output appears 2 cycles after accept.
REQ-035 Defaults, mode 10, 127.5 (0x7F80) -> out_data=0x7F, out_sat=1; -128.0 (0x8000) -> 0x80, out_sat=0.
REQ-036 OUT_W=6, mode 00: -32.0 (0xE000) -> 0x20, out_sat=0; -33.0 (0xDF00) -> 0x20, out_sat=1; 32.0 (0x2000) -> 0x1F, out_sat=1.
REQ-037 Back-to-back samples 1,2,3,4 with out_ready low for 5 cycles -> in_ready drops after 2 accepts, out_data holds at 1; on release, 1,2,3,4 are delivered in order with no gaps.
REQ-038 CNT_W=4, 20 saturating transfers -> sat_count=15; then cnt_clr together with a saturating transfer -> sat_count=0.
REQ-039 rst pulsed with both stages full -> next cycle out_valid=0, sat_count=0; the following sample has normal 2-cycle latency.
